// File: rtl/rubiks_polibot_pkg.sv
// rtl/rubiks_polibot_pkg.sv - move codes, servo codes, states and step tables
// Shared by the move sequencer and anything that issues moves to it.
package rubiks_polibot_pkg;

  localparam logic [2:0] MOV_NOP         = 3'd0;
  localparam logic [2:0] MOV_VIRA        = 3'd1;
  localparam logic [2:0] MOV_CUBO_H      = 3'd2;
  localparam logic [2:0] MOV_CUBO_AH     = 3'd3;
  localparam logic [2:0] MOV_CAMADA_H    = 3'd4;
  localparam logic [2:0] MOV_CAMADA_AH   = 3'd5;
  localparam logic [2:0] MOV_CAMADA_180  = 3'd6;
  localparam logic [2:0] MOV_REPOSICIONA = 3'd7;

  localparam logic [1:0] BASE_M90     = 2'd0;
  localparam logic [1:0] BASE_0       = 2'd1;
  localparam logic [1:0] BASE_P90     = 2'd2;
  localparam logic       TAMPA_ABERTA  = 1'b0;
  localparam logic       TAMPA_FECHADA = 1'b1;
  localparam logic       PET_REPOUSO   = 1'b0;
  localparam logic       PET_EMPURRA   = 1'b1;

  localparam logic [2:0] PASSOS_NOP         = 3'd0;
  localparam logic [2:0] PASSOS_VIRA        = 3'd2;
  localparam logic [2:0] PASSOS_CUBO        = 3'd1;
  localparam logic [2:0] PASSOS_CAMADA      = 3'd3;
  localparam logic [2:0] PASSOS_CAMADA_180  = 3'd4;
  localparam logic [2:0] PASSOS_REPOSICIONA = 3'd1;

  typedef enum logic [3:0] {
    EST_OCIOSO  = 4'd0,
    EST_EXECUTA = 4'd1,
    EST_FIM     = 4'd2
  } estado_t;

  typedef enum logic [2:0] {
    ACAO_NENHUMA,
    ACAO_PET_EMPURRA,
    ACAO_PET_REPOUSO,
    ACAO_BASE_MAIS,
    ACAO_BASE_MENOS,
    ACAO_TAMPA_FECHA,
    ACAO_TAMPA_ABRE,
    ACAO_BASE_CENTRO
  } acao_t;

  function automatic logic [2:0] num_passos(input logic [2:0] mov);
    case (mov)
      MOV_VIRA:        return PASSOS_VIRA;
      MOV_CUBO_H:      return PASSOS_CUBO;
      MOV_CUBO_AH:     return PASSOS_CUBO;
      MOV_CAMADA_H:    return PASSOS_CAMADA;
      MOV_CAMADA_AH:   return PASSOS_CAMADA;
      MOV_CAMADA_180:  return PASSOS_CAMADA_180;
      MOV_REPOSICIONA: return PASSOS_REPOSICIONA;
      default:         return PASSOS_NOP;
    endcase
  endfunction

  // Rejecting out-of-range turns up front keeps the 2-bit base from wrapping.
  function automatic logic movimento_legal(input logic [2:0] mov, input logic [1:0] base);
    case (mov)
      MOV_CUBO_H, MOV_CAMADA_H:   return base != BASE_P90;
      MOV_CUBO_AH, MOV_CAMADA_AH: return base != BASE_M90;
      MOV_CAMADA_180:             return base == BASE_M90;
      default:                    return 1'b1;
    endcase
  endfunction

  function automatic acao_t acao_do_passo(input logic [2:0] mov, input logic [1:0] passo);
    case (mov)
      MOV_VIRA:        return (passo == 2'd0) ? ACAO_PET_EMPURRA : ACAO_PET_REPOUSO;
      MOV_CUBO_H:      return ACAO_BASE_MAIS;
      MOV_CUBO_AH:     return ACAO_BASE_MENOS;
      MOV_CAMADA_H:    return (passo == 2'd0) ? ACAO_TAMPA_FECHA :
                              (passo == 2'd1) ? ACAO_BASE_MAIS : ACAO_TAMPA_ABRE;
      MOV_CAMADA_AH:   return (passo == 2'd0) ? ACAO_TAMPA_FECHA :
                              (passo == 2'd1) ? ACAO_BASE_MENOS : ACAO_TAMPA_ABRE;
      MOV_CAMADA_180:  return (passo == 2'd0) ? ACAO_TAMPA_FECHA :
                              (passo == 2'd3) ? ACAO_TAMPA_ABRE : ACAO_BASE_MAIS;
      MOV_REPOSICIONA: return ACAO_BASE_CENTRO;
      default:         return ACAO_NENHUMA;
    endcase
  endfunction

endpackage

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - up-counter with clear, enable and terminal-count flag
// Used as the servo settle timer; fim is high while the count equals LIMITE-1.
module contador_espera #(
  parameter int LARGURA = 25,
  parameter int LIMITE  = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim
);

  logic [LARGURA-1:0] r_valor;

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      r_valor <= '0;
    end else if (conta) begin
      r_valor <= r_valor + LARGURA'(1);
    end
  end

  assign fim = (r_valor == LARGURA'(LIMITE - 1));

endmodule

// File: rtl/sequenciador_movimento.sv
// rtl/sequenciador_movimento.sv - sequences servo position codes for one cube move
// Define MOV_CONTADOR_EN to enable the completed-move counter on db_num_movimentos.
module sequenciador_movimento
  import rubiks_polibot_pkg::*;
#(
  parameter int ESPERA_SERVO   = 25_000_000,
  parameter int LARGURA_ESPERA = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [2:0] movimento,
  output logic [1:0] pos_base,
  output logic       pos_tampa,
  output logic       pos_peteleco,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [7:0] db_num_movimentos
);

  estado_t    r_estado, w_prox_estado;
  logic [2:0] r_mov, w_prox_mov;
  logic [1:0] r_passo, w_prox_passo;
  logic       r_erro, w_prox_erro;
  logic [1:0] r_pos_base, w_prox_base;
  logic       r_pos_tampa, w_prox_tampa;
  logic       r_pos_pet, w_prox_pet;
  acao_t      w_acao;
  logic       w_fim_espera;
  logic       w_limpa_espera;
  logic       w_conta_espera;
  logic       w_ultimo_passo;

  assign w_conta_espera = (r_estado == EST_EXECUTA);
  assign w_limpa_espera = (r_estado != EST_EXECUTA) || w_fim_espera;
  assign w_ultimo_passo = ({1'b0, r_passo} == (num_passos(r_mov) - 3'd1));

  contador_espera #(
    .LARGURA (LARGURA_ESPERA),
    .LIMITE  (ESPERA_SERVO)
  ) u_espera (
    .clock (clock),
    .reset (reset),
    .limpa (w_limpa_espera),
    .conta (w_conta_espera),
    .fim   (w_fim_espera)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= EST_OCIOSO;
      r_mov       <= MOV_NOP;
      r_passo     <= 2'd0;
      r_erro      <= 1'b0;
      r_pos_base  <= BASE_0;
      r_pos_tampa <= TAMPA_ABERTA;
      r_pos_pet   <= PET_REPOUSO;
    end else begin
      r_estado    <= w_prox_estado;
      r_mov       <= w_prox_mov;
      r_passo     <= w_prox_passo;
      r_erro      <= w_prox_erro;
      r_pos_base  <= w_prox_base;
      r_pos_tampa <= w_prox_tampa;
      r_pos_pet   <= w_prox_pet;
    end
  end

  // Each step's servo update is registered on the same edge that enters the step.
  always_comb begin
    w_prox_estado = r_estado;
    w_prox_mov    = r_mov;
    w_prox_passo  = r_passo;
    w_prox_erro   = r_erro;
    w_prox_base   = r_pos_base;
    w_prox_tampa  = r_pos_tampa;
    w_prox_pet    = r_pos_pet;
    w_acao        = ACAO_NENHUMA;

    case (r_estado)
      EST_OCIOSO: begin
        if (iniciar) begin
          w_prox_mov = movimento;
          if (movimento == MOV_NOP || !movimento_legal(movimento, r_pos_base)) begin
            w_prox_estado = EST_FIM;
            w_prox_erro   = (movimento != MOV_NOP);
          end else begin
            w_prox_estado = EST_EXECUTA;
            w_prox_erro   = 1'b0;
            w_prox_passo  = 2'd0;
            w_acao        = acao_do_passo(movimento, 2'd0);
          end
        end
      end
      EST_EXECUTA: begin
        if (w_fim_espera) begin
          if (w_ultimo_passo) begin
            w_prox_estado = EST_FIM;
          end else begin
            w_prox_passo = r_passo + 2'd1;
            w_acao       = acao_do_passo(r_mov, r_passo + 2'd1);
          end
        end
      end
      EST_FIM: begin
        w_prox_estado = EST_OCIOSO;
      end
      default: begin
        w_prox_estado = EST_OCIOSO;
      end
    endcase

    case (w_acao)
      ACAO_PET_EMPURRA: w_prox_pet   = PET_EMPURRA;
      ACAO_PET_REPOUSO: w_prox_pet   = PET_REPOUSO;
      ACAO_BASE_MAIS:   w_prox_base  = r_pos_base + 2'd1;
      ACAO_BASE_MENOS:  w_prox_base  = r_pos_base - 2'd1;
      ACAO_TAMPA_FECHA: w_prox_tampa = TAMPA_FECHADA;
      ACAO_TAMPA_ABRE:  w_prox_tampa = TAMPA_ABERTA;
      ACAO_BASE_CENTRO: w_prox_base  = BASE_0;
      default: ;
    endcase
  end

  assign pos_base     = r_pos_base;
  assign pos_tampa    = r_pos_tampa;
  assign pos_peteleco = r_pos_pet;
  assign ocupado      = (r_estado != EST_OCIOSO);
  assign pronto       = (r_estado == EST_FIM);
  assign erro         = (r_estado == EST_FIM) && r_erro;
  assign db_estado    = r_estado;

`ifdef MOV_CONTADOR_EN
  logic [7:0] r_num_mov;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_num_mov <= 8'd0;
    end else if (r_estado == EST_FIM && !r_erro && r_mov != MOV_NOP && r_num_mov != 8'hFF) begin
      r_num_mov <= r_num_mov + 8'd1;
    end
  end

  assign db_num_movimentos = r_num_mov;
`else
  assign db_num_movimentos = 8'd0;
`endif

endmodule
